// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the register-bank read-out path.
//   dump_state_t : read-out FSM states
//   DATA_WIDTH   : default register word width
package cpu_pkg;

  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/word_capture_reg.sv
// Load-enabled holding register with asynchronous active-low clear.
//   clk, rst_n : clock, async active-low clear
//   load       : capture d on the next rising edge
//   d          : word to capture
//   q          : held word
module word_capture_reg #(
  parameter int WIDTH = cpu_pkg::DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/reg_dump_reader.sv
// Sequential read-out of the register bank onto a valid/ready stream.
// A start pulse in IDLE walks registers 0..NUM_REGS-1; each word is sampled
// in its own LOAD cycle (no bank snapshot) and held until accepted.
//   clk, rst_n  : clock, async active-low reset
//   start       : dump request, honoured only in IDLE
//   reg_data_in : flattened bank, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_sel     : register index currently being read
//   out_data    : captured word
//   out_valid   : out_data awaits acceptance
//   out_ready   : consumer accepts when out_valid && out_ready
//   busy        : any state but IDLE
//   done        : one-cycle pulse after the last word is accepted
module reg_dump_reader #(
  parameter  int NUM_REGS   = 8,
  parameter  int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  localparam int SEL_W      = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_data_in,
  output logic [SEL_W-1:0]             reg_sel,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_REGS - 1);

  cpu_pkg::dump_state_t state_q, state_d;
  logic [SEL_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= cpu_pkg::IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      cpu_pkg::IDLE: if (start) begin
        idx_d   = '0;
        state_d = cpu_pkg::LOAD;
      end
      cpu_pkg::LOAD: state_d = cpu_pkg::SEND;
      cpu_pkg::SEND: if (out_ready) begin
        // index saturates at LAST; it only returns to 0 via IDLE
        if (idx_q == LAST) state_d = cpu_pkg::DONE;
        else begin
          idx_d   = idx_q + 1'b1;
          state_d = cpu_pkg::LOAD;
        end
      end
      cpu_pkg::DONE: state_d = cpu_pkg::IDLE;
      default:       state_d = cpu_pkg::IDLE;
    endcase
  end

  // slice mux: register idx_q of the live bank
  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (idx_q == SEL_W'(i)) word = reg_data_in[i*DATA_WIDTH +: DATA_WIDTH];
  end

  word_capture_reg #(.WIDTH(DATA_WIDTH)) u_cap (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state_q == cpu_pkg::LOAD),
    .d     (word),
    .q     (out_data)
  );

  // a word is pending exactly while in SEND, so valid follows the state
  assign out_valid = (state_q == cpu_pkg::SEND);
  assign busy      = (state_q != cpu_pkg::IDLE);
  assign done      = (state_q == cpu_pkg::DONE);
  assign reg_sel   = idx_q;

endmodule
